// File: rtl/serial_adder_unit.sv
// serial_adder_unit: digit-serial WIDTH-bit adder/subtractor with an internal
// accumulator. Operands are captured on acceptance, then DIGIT bits are summed
// per clock, LSB first, through a registered carry. The result is held with
// valid/ready backpressure and written back into the accumulator R.
module serial_adder_unit #(
  parameter int WIDTH = 8,
  parameter int DIGIT = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic [1:0]       in_op,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_sum,
  output logic             out_cout,
  output logic             out_ovf,
  output logic             out_zero,
  output logic             busy
);

  localparam int NCYC  = WIDTH / DIGIT;
  localparam int CNT_W = (NCYC > 1) ? $clog2(NCYC) : 1;
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(NCYC - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t r_state;
  state_t w_state_nxt;

  logic [WIDTH-1:0] r_x;
  logic [WIDTH-1:0] r_y;
  logic [WIDTH-1:0] r_res;
  logic             r_carry;
  logic [CNT_W-1:0] r_cnt;
  logic [WIDTH-1:0] r_acc;
  logic [WIDTH-1:0] r_sum;
  logic             r_cout;
  logic             r_ovf;
  logic             r_zero;

  logic             w_accept;
  logic             w_last;
  logic [DIGIT:0]   w_dsum;
  logic             w_cin_msb;
  logic [WIDTH-1:0] w_res_shift;
  logic [WIDTH-1:0] w_res_nxt;

  // Handshake decode: only IDLE accepts, only DONE presents a result.
  assign in_ready  = (r_state == S_IDLE);
  assign out_valid = (r_state == S_DONE);
  assign busy      = (r_state != S_IDLE);
  assign w_accept  = (r_state == S_IDLE) && in_valid;
  assign w_last    = (r_state == S_RUN) && (r_cnt == LAST_CNT);

  // One digit of sum: low DIGIT bits of X and Y plus the registered carry.
  assign w_dsum = {1'b0, r_x[DIGIT-1:0]} + {1'b0, r_y[DIGIT-1:0]}
                + {{DIGIT{1'b0}}, r_carry};

  // Carry into the top bit of this digit, recovered from the sum bit and the
  // two operand bits; on the final digit this is the carry into the MSB.
  assign w_cin_msb = w_dsum[DIGIT-1] ^ r_x[DIGIT-1] ^ r_y[DIGIT-1];

  // New digit enters at the top of the result; earlier digits move down.
  assign w_res_shift = r_res >> DIGIT;
  assign w_res_nxt   = w_res_shift | (WIDTH'(w_dsum[DIGIT-1:0]) << (WIDTH - DIGIT));

  assign out_sum  = r_sum;
  assign out_cout = r_cout;
  assign out_ovf  = r_ovf;
  assign out_zero = r_zero;

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state logic: IDLE -> RUN on accept, RUN -> DONE on last digit,
  // DONE -> IDLE when the consumer takes the result.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE: if (in_valid)  w_state_nxt = S_RUN;
      S_RUN:  if (w_last)    w_state_nxt = S_DONE;
      S_DONE: if (out_ready) w_state_nxt = S_IDLE;
      default:               w_state_nxt = S_IDLE;
    endcase
  end

  // Datapath: operand capture on accept, digit-serial shift/add while running,
  // result/flag/accumulator update on the final digit.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_x     <= '0;
      r_y     <= '0;
      r_res   <= '0;
      r_carry <= 1'b0;
      r_cnt   <= '0;
      r_acc   <= '0;
      r_sum   <= '0;
      r_cout  <= 1'b0;
      r_ovf   <= 1'b0;
      r_zero  <= 1'b0;
    end else if (w_accept) begin
      r_x     <= in_op[1] ? r_acc : in_a;
      r_y     <= in_op[0] ? ~in_b : in_b;
      r_carry <= in_op[0];
      r_res   <= '0;
      r_cnt   <= '0;
    end else if (r_state == S_RUN) begin
      r_x     <= r_x >> DIGIT;
      r_y     <= r_y >> DIGIT;
      r_carry <= w_dsum[DIGIT];
      r_res   <= w_res_nxt;
      if (w_last) begin
        r_sum  <= w_res_nxt;
        r_cout <= w_dsum[DIGIT];
        r_ovf  <= w_cin_msb ^ w_dsum[DIGIT];
        r_zero <= (w_res_nxt == '0);
        r_acc  <= w_res_nxt;
      end else begin
        r_cnt <= r_cnt + CNT_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_serial_adder_unit.sv
// Bench for serial_adder_unit: one instance with DIGIT=1 and one with DIGIT=4,
// table-driven vectors plus hand-written backpressure and reset sequences.
module tb_serial_adder_unit;

  typedef struct packed {
    logic [7:0] sum;
    logic       cout;
    logic       ovf;
    logic       zero;
  } exp_t;

  typedef struct packed {
    logic [7:0] a;
    logic [7:0] b;
    logic [1:0] op;
    logic [7:0] sum;
    logic       cout;
    logic       ovf;
    logic       zero;
  } vec_t;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [7:0] in_a, in_b;
  logic [1:0] in_op;
  logic       out_ready;
  logic       tb_in_valid;
  logic       sel4;

  logic       iv1, ir1, ov1, c1, v1, z1, b1;
  logic [7:0] s1;
  logic       iv4, ir4, ov4, c4, v4, z4, b4;
  logic [7:0] s4;

  logic       g_ir, g_ov, g_c, g_v, g_z, g_b;
  logic [7:0] g_s;

  int   checks   = 0;
  int   failures = 0;
  exp_t sbq[$];
  logic [7:0] rm1, rm4;
  vec_t vecs[9];

  always #5 clk = ~clk;

  assign iv1 = tb_in_valid & ~sel4;
  assign iv4 = tb_in_valid & sel4;

  assign g_ir = sel4 ? ir4 : ir1;
  assign g_ov = sel4 ? ov4 : ov1;
  assign g_s  = sel4 ? s4  : s1;
  assign g_c  = sel4 ? c4  : c1;
  assign g_v  = sel4 ? v4  : v1;
  assign g_z  = sel4 ? z4  : z1;
  assign g_b  = sel4 ? b4  : b1;

  serial_adder_unit #(.WIDTH(8), .DIGIT(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .in_valid(iv1), .in_ready(ir1),
    .in_a(in_a), .in_b(in_b), .in_op(in_op), .out_valid(ov1),
    .out_ready(out_ready), .out_sum(s1), .out_cout(c1), .out_ovf(v1),
    .out_zero(z1), .busy(b1)
  );

  serial_adder_unit #(.WIDTH(8), .DIGIT(4)) dut4 (
    .clk(clk), .rst_n(rst_n), .in_valid(iv4), .in_ready(ir4),
    .in_a(in_a), .in_b(in_b), .in_op(in_op), .out_valid(ov4),
    .out_ready(out_ready), .out_sum(s4), .out_cout(c4), .out_ovf(v4),
    .out_zero(z4), .busy(b4)
  );

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, req);
    end
  endtask

  // Full-width reference: X + Y + c with Y inverted and c=1 for subtract.
  function automatic exp_t model(input logic [7:0] a, input logic [7:0] b,
                                 input logic [7:0] r, input logic [1:0] op);
    logic [7:0] x, y;
    logic [8:0] t;
    exp_t m;
    x = op[1] ? r : a;
    y = op[0] ? ~b : b;
    t = {1'b0, x} + {1'b0, y} + {8'd0, op[0]};
    m.sum  = t[7:0];
    m.cout = t[8];
    m.ovf  = (x[7] == y[7]) && (t[7] != x[7]);
    m.zero = (t[7:0] == 8'd0);
    return m;
  endfunction

  task automatic do_op(input logic [7:0] a, input logic [7:0] b,
                       input logic [1:0] op, input exp_t e, input string nm);
    exp_t got;
    int   n;
    bit   seen;
    sbq.push_back(e);
    @(negedge clk);
    in_a = a; in_b = b; in_op = op; tb_in_valid = 1'b1;
    chk({nm, ".in_ready"}, 32'(g_ir), 32'd1);
    @(posedge clk);
    #1 tb_in_valid = 1'b0;
    chk({nm, ".busy"}, 32'(g_b), 32'd1);
    seen = 1'b0;
    n = 0;
    while (!seen && n < 40) begin
      @(posedge clk);
      #1;
      n++;
      if (g_ov) seen = 1'b1;
    end
    if (!seen) begin
      checks++;
      failures++;
      $display("FAIL %s.timeout actual=no_out_valid required=out_valid", nm);
      void'(sbq.pop_front());
    end else begin
      got = sbq.pop_front();
      chk({nm, ".latency"}, 32'(n), sel4 ? 32'd2 : 32'd8);
      chk({nm, ".sum"},  32'(g_s), 32'(got.sum));
      chk({nm, ".cout"}, 32'(g_c), 32'(got.cout));
      chk({nm, ".ovf"},  32'(g_v), 32'(got.ovf));
      chk({nm, ".zero"}, 32'(g_z), 32'(got.zero));
      if (out_ready) begin
        @(posedge clk);
        #1;
        chk({nm, ".release_valid"}, 32'(g_ov), 32'd0);
        chk({nm, ".release_ready"}, 32'(g_ir), 32'd1);
      end
    end
  endtask

  initial begin
    exp_t e;
    logic [7:0] ra, rb;
    logic [1:0] rop;

    vecs[0] = {8'h55, 8'hFF, 2'b10, 8'hFF, 3'b000};
    vecs[1] = {8'h55, 8'h01, 2'b10, 8'h00, 3'b101};
    vecs[2] = {8'h55, 8'h01, 2'b11, 8'hFF, 3'b000};
    vecs[3] = {8'h7F, 8'h01, 2'b00, 8'h80, 3'b010};
    vecs[4] = {8'h05, 8'h07, 2'b01, 8'hFE, 3'b000};
    vecs[5] = {8'h80, 8'h01, 2'b01, 8'h7F, 3'b110};
    vecs[6] = {8'h00, 8'h01, 2'b10, 8'h80, 3'b010};
    vecs[7] = {8'h00, 8'h01, 2'b11, 8'h7F, 3'b110};
    vecs[8] = {8'h00, 8'h00, 2'b01, 8'h00, 3'b101};

    rst_n = 1'b0; tb_in_valid = 1'b0; sel4 = 1'b0;
    in_a = 8'h00; in_b = 8'h00; in_op = 2'b00; out_ready = 1'b1;
    rm1 = 8'h00; rm4 = 8'h00;

    #3;
    chk("reset.dut1", 32'({ir1, ov1, s1, c1, v1, z1, b1}), 32'({1'b1, 13'd0}));
    chk("reset.dut4", 32'({ir4, ov4, s4, c4, v4, z4, b4}), 32'({1'b1, 13'd0}));
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;

    // Table of accumulate / add / subtract vectors on the DIGIT=1 engine.
    for (int i = 0; i < 9; i++) begin
      e = {vecs[i].sum, vecs[i].cout, vecs[i].ovf, vecs[i].zero};
      do_op(vecs[i].a, vecs[i].b, vecs[i].op, e, $sformatf("vec%0d", i));
      rm1 = e.sum;
    end

    // Backpressure: result held for 20 cycles while in_valid pulses.
    out_ready = 1'b0;
    e = {8'h46, 3'b000};
    do_op(8'h12, 8'h34, 2'b00, e, "bp");
    rm1 = e.sum;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      tb_in_valid = i[0];
      in_a = 8'hFF; in_b = 8'hFF; in_op = 2'b00;
      @(posedge clk);
      #1;
      chk("bp.hold_valid", 32'(g_ov), 32'd1);
      chk("bp.hold_sum",   32'(g_s),  32'h46);
      chk("bp.hold_ready", 32'(g_ir), 32'd0);
    end
    @(negedge clk);
    tb_in_valid = 1'b0;
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    chk("bp.release_valid", 32'(g_ov), 32'd0);
    chk("bp.release_ready", 32'(g_ir), 32'd1);
    chk("bp.keep_sum",      32'(g_s),  32'h46);
    repeat (3) @(posedge clk);
    #1;
    chk("bp.no_queue_busy",  32'(g_b),  32'd0);
    chk("bp.no_queue_valid", 32'(g_ov), 32'd0);
    e = model(8'h00, 8'h00, rm1, 2'b10);
    do_op(8'h00, 8'h00, 2'b10, e, "bp.acc");
    rm1 = e.sum;

    // Reset in the middle of a run discards it and clears R.
    @(negedge clk);
    in_a = 8'h10; in_b = 8'h20; in_op = 2'b00; tb_in_valid = 1'b1;
    @(posedge clk);
    #1 tb_in_valid = 1'b0;
    repeat (3) @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("midrst.dut1", 32'({ir1, ov1, s1, c1, v1, z1, b1}), 32'({1'b1, 13'd0}));
    @(negedge clk);
    rst_n = 1'b1;
    rm1 = 8'h00; rm4 = 8'h00;
    repeat (2) @(posedge clk);
    #1;
    chk("midrst.idle", 32'({ir1, ov1, b1}), 32'b100);
    e = {8'h03, 3'b000};
    do_op(8'hAA, 8'h03, 2'b10, e, "midrst.acc");
    rm1 = e.sum;

    // DIGIT=4 engine.
    sel4 = 1'b1;
    e = {8'h00, 3'b101};
    do_op(8'hFF, 8'h01, 2'b00, e, "d4.wrap");
    rm4 = e.sum;
    for (int k = 0; k < 6; k++) begin
      ra = 8'($urandom); rb = 8'($urandom); rop = 2'($urandom_range(0, 3));
      e = model(ra, rb, rm4, rop);
      do_op(ra, rb, rop, e, $sformatf("d4.rnd%0d", k));
      rm4 = e.sum;
    end

    // Random mix on the DIGIT=1 engine.
    sel4 = 1'b0;
    for (int k = 0; k < 6; k++) begin
      ra = 8'($urandom); rb = 8'($urandom); rop = 2'($urandom_range(0, 3));
      e = model(ra, rb, rm1, rop);
      do_op(ra, rb, rop, e, $sformatf("d1.rnd%0d", k));
      rm1 = e.sum;
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog actual=running required=finished");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/serial_adder_unit.md
Name: serial_adder_unit

Overview:
Parametrised multi-bit adder/subtractor that processes DIGIT bits per clock, LSB first, through a registered carry. It replaces the single-bit combinational sum/carry logic in the tile datapath with a WIDTH-bit engine. The engine has valid/ready handshakes on input and output, an internal accumulator, and signed and unsigned status flags. It sits between the tile's input pins and its output register bank.

Parameters:
WIDTH, 8, operand/result width in bits; must be at least 2.
DIGIT, 1, bits processed per cycle; must divide WIDTH; NCYC = WIDTH/DIGIT.

Ports:
clk  in  1  clock
rst_n  in  1  asynchronous active-low reset
in_valid  in  1  operand request valid
in_ready  out  1  engine can accept an operand
in_a  in  WIDTH  operand A (ignored for op 10/11)
in_b  in  WIDTH  operand B
in_op  in  2  00 A+B, 01 A-B, 10 R+B, 11 R-B (R = accumulator)
out_valid  out  1  result valid
out_ready  in  1  consumer accepts result
out_sum  out  WIDTH  result, modulo 2^WIDTH
out_cout  out  1  final carry; for subtract, 1 = no borrow
out_ovf  out  1  signed two's-complement overflow
out_zero  out  1  out_sum == 0
busy  out  1  state != IDLE

Behaviour:
- Reset (async, rst_n=0):
  - State = IDLE.
  - in_ready=1, out_valid=0, out_sum=0, out_cout=0, out_ovf=0, out_zero=0, busy=0.
  - Accumulator R=0, cycle counter=0, carry=0, shift registers=0.
- States IDLE, RUN, DONE.
- IDLE:
  - in_ready=1.
  - Accept on a clock edge where in_valid=1.
  - Capture operand X = in_a (op 0x) or R (op 1x).
  - Capture Y = in_b, inverted when op[0]=1.
  - Carry register = op[0].
  - Counter = 0. Go to RUN.
- RUN:
  - in_ready=0.
  - Each cycle, add the low DIGIT bits of X and Y plus carry.
  - Shift the DIGIT-bit sum into the top of the result shift register; shift X and Y right by DIGIT; update carry.
  - Record the carry into the MSB of the final digit to compute overflow: ovf = carry_into_msb XOR carry_out_of_msb.
  - On the cycle where counter == NCYC-1: load out_sum, out_cout, out_ovf and out_zero from the completed result, set out_valid=1, write R = result, go to DONE. Otherwise counter += 1.
- Latency: out_valid rises exactly NCYC clock edges after the acceptance edge. WIDTH=8/DIGIT=1 gives 8; DIGIT=4 gives 2.
- DONE:
  - out_valid=1; out_* are stable and held while out_ready=0, for unlimited backpressure.
  - On an edge with out_ready=1: out_valid=0, go to IDLE. out_* keep their last value.
- No overlap: a new operand is accepted only in IDLE, never on the same edge as a DONE→IDLE handoff. Throughput is therefore one result per NCYC+2 cycles at best.
- in_a, in_b and in_op are sampled only on the acceptance edge. Changes during RUN/DONE have no effect.
- Accumulator: updated only at result completion, and wraps modulo 2^WIDTH. op 10 with R=0 yields B.
- Subtract carry: out_cout=1 when A >= B unsigned. out_ovf follows two's-complement rules for both add and subtract.
- Reset asserted mid-RUN or in DONE: the in-flight result is discarded, all outputs return to reset values immediately, and R=0.
- in_valid held high in RUN/DONE is ignored and does not queue.

Test Plan:
- W=8,D=1: A=0x7F, B=0x01, op 00 → out_valid exactly 8 edges after accept; sum=0x80, cout=0, ovf=1, zero=0.
- W=8,D=1: A=0x05, B=0x07, op 01 → sum=0xFE, cout=0, ovf=0. Then A=0x80, B=0x01, op 01 → sum=0x7F, cout=1, ovf=1.
- Accumulate, W=8,D=1: op 10 B=0xFF → sum 0xFF (R was 0); op 10 B=0x01 → sum 0x00, cout=1, zero=1; op 11 B=0x01 → sum 0xFF, cout=0.
- Backpressure: hold out_ready=0 for 20 cycles in DONE → out_valid and out_sum stable; in_ready=0; in_valid pulses ignored. Release → out_valid falls after 1 edge, in_ready=1.
- W=8,D=4: A=0xFF, B=0x01, op 00 → out_valid 2 edges after accept; sum=0x00, cout=1, zero=1, ovf=0.
- Reset mid-RUN, after 3 cycles of a W=8,D=1 add: all outputs 0 asynchronously, in_ready=1, busy=0. The next op 10 B=0x03 → sum 0x03, confirming R was cleared.
